// File: rtl/debounce_sync.sv
// Switch/button debouncer with a two-flop synchronizer.
// The synchronized input s must differ from q for STABLE_CYCLES consecutive
// edges before q follows it. Pulses on rise/fall mark each accepted change.
//
// Ports:
//   clk  - single clock, rising edge
//   rst  - synchronous active-high reset
//   din  - raw asynchronous level input (may bounce)
//   q    - debounced, synchronized level (registered)
//   rise - one-cycle pulse coincident with q going 0->1 (registered)
//   fall - one-cycle pulse coincident with q going 1->0 (registered)
//   busy - high while a level change is pending (registered)
module debounce_sync #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic q,
    output logic rise,
    output logic fall,
    output logic busy
);

    localparam int unsigned CW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        S_LOW       = 2'd0,
        S_PEND_HIGH = 2'd1,
        S_HIGH      = 2'd2,
        S_PEND_LOW  = 2'd3
    } state_t;

    logic          ff1;
    logic          ff2;
    logic          s;
    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          q_nxt;
    logic          rise_nxt;
    logic          fall_nxt;
    logic          busy_nxt;

    assign s = ff2;

    // Synchronizer, state, counter and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            ff1   <= 1'b0;
            ff2   <= 1'b0;
            state <= S_LOW;
            cnt   <= '0;
            q     <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
            busy  <= 1'b0;
        end else begin
            ff1   <= din;
            ff2   <= ff1;
            state <= state_nxt;
            cnt   <= cnt_nxt;
            q     <= q_nxt;
            rise  <= rise_nxt;
            fall  <= fall_nxt;
            busy  <= busy_nxt;
        end
    end

    // Next-state, counter and output decode. cnt tracks consecutive edges
    // with s != q; it restarts at zero whenever s agrees with q again.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = '0;
        rise_nxt  = 1'b0;
        fall_nxt  = 1'b0;

        case (state)
            S_LOW: begin
                if (s) begin
                    if (STABLE_CYCLES == 1) begin
                        state_nxt = S_HIGH;
                        rise_nxt  = 1'b1;
                    end else begin
                        state_nxt = S_PEND_HIGH;
                        cnt_nxt   = CNT_ONE;
                    end
                end
            end
            S_PEND_HIGH: begin
                if (!s) begin
                    state_nxt = S_LOW;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = S_HIGH;
                    rise_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            S_HIGH: begin
                if (!s) begin
                    if (STABLE_CYCLES == 1) begin
                        state_nxt = S_LOW;
                        fall_nxt  = 1'b1;
                    end else begin
                        state_nxt = S_PEND_LOW;
                        cnt_nxt   = CNT_ONE;
                    end
                end
            end
            S_PEND_LOW: begin
                if (s) begin
                    state_nxt = S_HIGH;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = S_LOW;
                    fall_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            default: begin
                state_nxt = S_LOW;
            end
        endcase

        q_nxt    = (state_nxt == S_HIGH) || (state_nxt == S_PEND_LOW);
        busy_nxt = (state_nxt == S_PEND_HIGH) || (state_nxt == S_PEND_LOW);
    end

endmodule

// File: tb/tb_debounce_sync.sv
// Bench for debounce_sync: one instance with STABLE_CYCLES=4 and one with
// STABLE_CYCLES=1 share clk/rst/din. A window-based reference model predicts
// q/rise/fall/busy for both after every edge; directed scenarios add
// edge-position and pulse-count checks.
module tb_debounce_sync;

    logic clk = 1'b0;
    logic rst;
    logic din;
    logic q4, r4, f4, b4;
    logic q1, r1, f1, b1;

    int total = 0;
    int bad   = 0;

    // Reference model state, index 0 -> N=4, index 1 -> N=1.
    logic        m_ff1  [2];
    logic        m_ff2  [2];
    logic        m_q    [2];
    logic        m_rise [2];
    logic        m_fall [2];
    logic        m_busy [2];
    logic [15:0] m_win  [2];
    int          m_fill [2];

    // Scenario bookkeeping taken from the DUT outputs.
    int rise4_cnt, fall4_cnt, busy4_cnt, rise1_cnt, busy1_cnt;
    int rise4_edge, fall4_edge, rise1_edge;
    int edge_no;

    debounce_sync #(.STABLE_CYCLES(4)) dut4 (
        .clk(clk), .rst(rst), .din(din),
        .q(q4), .rise(r4), .fall(f4), .busy(b4)
    );

    debounce_sync #(.STABLE_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .din(din),
        .q(q1), .rise(r1), .fall(f1), .busy(b1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        total++;
        assert (obs == exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // q changes at an edge when the last n synchronized samples since reset
    // all disagree with the current q.
    task automatic model_edge(input int i, input int n, input logic d, input logic r);
        logic        s;
        logic [15:0] mask;
        mask = 16'((32'd1 << n) - 32'd1);
        if (r) begin
            m_ff1[i]  = 1'b0;
            m_ff2[i]  = 1'b0;
            m_q[i]    = 1'b0;
            m_rise[i] = 1'b0;
            m_fall[i] = 1'b0;
            m_busy[i] = 1'b0;
            m_win[i]  = '0;
            m_fill[i] = 0;
        end else begin
            s         = m_ff2[i];
            m_ff2[i]  = m_ff1[i];
            m_ff1[i]  = d;
            m_win[i]  = {m_win[i][14:0], s};
            if (m_fill[i] < 16) m_fill[i]++;
            m_rise[i] = 1'b0;
            m_fall[i] = 1'b0;
            if (m_fill[i] >= n && (m_win[i] & mask) == (m_q[i] ? 16'h0000 : mask)) begin
                m_q[i]    = ~m_q[i];
                m_rise[i] = m_q[i];
                m_fall[i] = ~m_q[i];
            end
            m_busy[i] = (s != m_q[i]);
        end
    endtask

    task automatic clear_stats();
        rise4_cnt  = 0; fall4_cnt = 0; busy4_cnt = 0;
        rise1_cnt  = 0; busy1_cnt = 0;
        rise4_edge = 0; fall4_edge = 0; rise1_edge = 0;
        edge_no    = 0;
    endtask

    // One clock edge: drive inputs, advance the model, check both DUTs.
    task automatic step(input logic d, input logic r);
        din = d;
        rst = r;
        @(posedge clk);
        model_edge(0, 4, d, r);
        model_edge(1, 1, d, r);
        #1;
        edge_no++;
        chk("q_n4",    q4, m_q[0]);
        chk("rise_n4", r4, m_rise[0]);
        chk("fall_n4", f4, m_fall[0]);
        chk("busy_n4", b4, m_busy[0]);
        chk("q_n1",    q1, m_q[1]);
        chk("rise_n1", r1, m_rise[1]);
        chk("fall_n1", f1, m_fall[1]);
        chk("busy_n1", b1, m_busy[1]);
        if (r4) begin rise4_cnt++; rise4_edge = edge_no; end
        if (f4) begin fall4_cnt++; fall4_edge = edge_no; end
        if (b4) busy4_cnt++;
        if (r1) begin rise1_cnt++; rise1_edge = edge_no; end
        if (b1) busy1_cnt++;
    endtask

    initial begin
        int run_len;
        logic lvl;
        din = 1'b0;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            m_ff1[i] = 1'b0; m_ff2[i] = 1'b0; m_q[i] = 1'b0;
            m_rise[i] = 1'b0; m_fall[i] = 1'b0; m_busy[i] = 1'b0;
            m_win[i] = '0; m_fill[i] = 0;
        end
        clear_stats();

        // Reset held three edges with din low.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
        chk("reset_q",    q4, 1'b0);
        chk("reset_busy", b4, 1'b0);

        // Clean 0->1: rise on the 6th edge (N=4) / 3rd edge (N=1).
        clear_stats();
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0);
        chk_int("up_rise_cnt_n4",  rise4_cnt,  1);
        chk_int("up_rise_edge_n4", rise4_edge, 6);
        chk_int("up_busy_cyc_n4",  busy4_cnt,  3);
        chk_int("up_rise_edge_n1", rise1_edge, 3);
        chk_int("up_busy_cyc_n1",  busy1_cnt,  0);

        // Clean 1->0: fall on the 6th edge.
        clear_stats();
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0);
        chk_int("down_fall_cnt_n4",  fall4_cnt,  1);
        chk_int("down_fall_edge_n4", fall4_edge, 6);
        chk_int("down_rise_cnt_n4",  rise4_cnt,  0);

        // Short pulse of 3 cycles is rejected.
        clear_stats();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0);
        chk_int("glitch_rise_cnt_n4", rise4_cnt, 0);
        chk("glitch_q_n4",    q4, 1'b0);
        chk("glitch_busy_n4", b4, 1'b0);

        // Reset in the middle of a pending rise, din kept high.
        clear_stats();
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
        for (int i = 0; i < 2; i++) step(1'b1, 1'b1);
        chk_int("rstpend_rise_cnt_n4", rise4_cnt, 0);
        clear_stats();
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0);
        chk_int("rstpend_rise_edge_n4", rise4_edge, 6);
        chk_int("rstpend_rise_cnt_n4b", rise4_cnt,  1);

        // Bring q back low, then toggle every cycle and settle high.
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0);
        clear_stats();
        for (int i = 0; i < 8; i++) step(((i % 2) == 0) ? 1'b1 : 1'b0, 1'b0);
        chk_int("toggle_rise_cnt_n4", rise4_cnt, 0);
        clear_stats();
        for (int i = 0; i < 12; i++) step(1'b1, 1'b0);
        chk_int("settle_rise_cnt_n4",  rise4_cnt,  1);
        chk_int("settle_rise_edge_n4", rise4_edge, 6);
        chk_int("settle_fall_cnt_n4",  fall4_cnt,  0);

        // Random bouncing runs with occasional resets.
        lvl = 1'b0;
        for (int k = 0; k < 120; k++) begin
            lvl     = ~lvl;
            run_len = int'($urandom_range(1, 8));
            if ($urandom_range(0, 39) == 0) begin
                for (int j = 0; j < int'($urandom_range(1, 2)); j++) step(lvl, 1'b1);
            end
            for (int j = 0; j < run_len; j++) step(lvl, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/debounce_sync.md
DEBOUNCE_SYNC -- requirements
Module: debounce_sync

Interface
REQ-001 Parameter: STABLE_CYCLES, default 4, number of consecutive clock edges the synchronized input must differ from q before q changes; legal range 1..65535.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous and active-high; takes effect only on a rising clk edge.
REQ-004 Port: din  input  1  raw asynchronous level input (switch/button), may bounce or glitch.
REQ-005 Port: q  output  1  debounced, synchronized level; registered.
REQ-006 Port: rise  output  1  one-cycle pulse coincident with q going 0->1; registered.
REQ-007 Port: fall  output  1  one-cycle pulse coincident with q going 1->0; registered.
REQ-008 Port: busy  output  1  high while a level change is pending (counter running); registered.

Function
REQ-009 din SHALL pass through exactly two flip-flops (ff1, ff2) before any use; ff2 output is s.
REQ-010 Control SHALL be a four-state FSM: S_LOW (q=0), S_PEND_HIGH (q=0, busy=1), S_HIGH (q=1), S_PEND_LOW (q=1, busy=1).
REQ-011 A counter cnt SHALL count consecutive edges with s != q; width = max(1, ceil(log2(STABLE_CYCLES))); cnt SHALL never wrap.
REQ-012 S_LOW, s=1: if STABLE_CYCLES=1 go S_HIGH and pulse rise; else go S_PEND_HIGH, cnt<=1.
REQ-013 S_PEND_HIGH, s=0: go S_LOW, cnt<=0, no pulse.
REQ-014 S_PEND_HIGH, s=1, cnt=STABLE_CYCLES-1: go S_HIGH, cnt<=0, rise<=1 for that one cycle.
REQ-015 S_PEND_HIGH, s=1, otherwise: cnt<=cnt+1, stay.
REQ-016 S_HIGH/S_PEND_LOW SHALL mirror REQ-012..015 with s=0 as trigger and fall as the pulse.
REQ-017 Stable states with s=q: hold, cnt=0, rise=fall=0.
REQ-018 Latency: if din changes before edge E0 and stays stable, q, rise/fall change on edge E0+STABLE_CYCLES+1 (the (STABLE_CYCLES+2)th edge sampling new din).
REQ-019 busy SHALL be high for exactly STABLE_CYCLES-1 cycles immediately preceding a q transition; never high with STABLE_CYCLES=1.
REQ-020 rise and fall SHALL never be high in the same cycle; each pulse lasts exactly one cycle.
REQ-021 Any input pulse shorter than STABLE_CYCLES cycles at s SHALL produce no q change and no pulse.

Reset
REQ-022 rst=1 at an edge SHALL force ff1=0, ff2=0, state=S_LOW, cnt=0, q=0, rise=0, fall=0, busy=0, overriding all other conditions.
REQ-023 Reset during a pending state SHALL discard the pending change with no pulse.
REQ-024 After release with din=1, the block SHALL treat din as a new 0->1 change: rise fires on the (STABLE_CYCLES+2)th post-release edge.

Verification (STABLE_CYCLES=4, 10 ns clock)
REQ-025 rst held 3 edges, din=0, release; din->1 held 10 cycles -> q=1 and rise=1 for one cycle on the 6th edge sampling din=1; busy=1 for the 3 preceding cycles.
REQ-026 From q=0, din=1 for 3 cycles then 0 -> q stays 0, rise never asserts, busy returns 0 within 1 cycle after s falls.
REQ-027 From q=1, din->0 held 8 cycles -> q=0 and fall=1 for one cycle on the 6th edge sampling din=0; rise stays 0.
REQ-028 din=1, rst asserted 4 edges later for 2 edges, din kept 1 -> q=0, busy=0 during reset, no pulse; rise on 6th edge after release.
REQ-029 din toggles every cycle for 8 cycles, then holds 1 -> exactly one rise pulse, 6 edges after final settle; no fall pulse.
REQ-030 Re-run REQ-025 with STABLE_CYCLES=1 -> q and rise change on the 3rd edge sampling din=1; busy stays 0.
